// File: rtl/imem_responder64_pkg.sv
// Shared types and helpers for the 64-bit instruction-memory responder.
package imem_responder64_pkg;

    localparam int unsigned IMEM_DW_BYTES = 8;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [63:0] rdata;
    } imem_resp_t;

    // 33-bit offset so a fetch below the base borrows instead of wrapping into range.
    function automatic logic imem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
        logic [32:0] offs;
        offs = {1'b0, addr} - {1'b0, base};
        return !offs[32] && (offs < {1'b0, size});
    endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// Delay line of imem_resp_t entries with synchronous clear; Depth 0 is a wire.
module imem_resp_pipe
    import imem_responder64_pkg::*;
#(
    parameter int unsigned Depth = 0
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  imem_resp_t in_i,
    output imem_resp_t out_o
);

    if (Depth == 0) begin : g_bypass
        logic unused_clk_clr;
        assign unused_clk_clr = clk_i ^ clr_i;
        assign out_o = in_i;
    end else begin : g_regs
        imem_resp_t stage_q [Depth];

        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= in_i;
                for (int unsigned i = 1; i < Depth; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign out_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/imem_responder64.sv
// Instruction-fetch target: decodes a window, reads a shared 64-bit SRAM, answers in order.
// Optional parity checking on SRAM data is enabled with IMEM_RESP_PARITY_EN.
module imem_responder64
    import imem_responder64_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter logic [31:0] SizeBytes      = 32'h0001_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [63:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [28:0] mem_addr_o,
    input  logic [63:0] mem_rdata_i,
`ifdef IMEM_RESP_PARITY_EN
    input  logic [7:0]  mem_par_i,
    output logic        par_err_o,
`endif
    output logic        busy_o
);

    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam int unsigned DwShift = $clog2(IMEM_DW_BYTES);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic [CntW-1:0] count_q, count_d;
    logic            in_range, slot_free;
    logic            s0_valid_q, s0_oor_q;
    logic [63:0]     rdata_q;
    logic            err_q;
    imem_resp_t      s1_resp, out_resp;

    assign in_range  = imem_in_range(instr_addr_i, BaseAddr, SizeBytes);
    assign slot_free = count_q < MaxCnt;

    assign instr_gnt_o = ~rst_i & instr_req_i & slot_free & (~in_range | mem_gnt_i);
    assign mem_req_o   = ~rst_i & instr_req_i & in_range & slot_free;
    assign mem_addr_o  = instr_addr_i[31:DwShift] - BaseAddr[31:DwShift];

    always_comb begin
        count_d = count_q;
        if (instr_gnt_o && !instr_rvalid_o) begin
            count_d = count_q + 1'b1;
        end else if (!instr_gnt_o && instr_rvalid_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            s0_valid_q <= 1'b0;
            s0_oor_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            s0_valid_q <= instr_gnt_o;
            s0_oor_q   <= ~in_range;
        end
    end

`ifdef IMEM_RESP_PARITY_EN
    logic par_bad;
    always_comb begin
        par_bad = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            par_bad = par_bad | (^{mem_rdata_i[8*i +: 8], mem_par_i[i]});
        end
    end
    assign par_err_o = ~rst_i & s0_valid_q & ~s0_oor_q & par_bad;
`endif

    // Stage 1: SRAM data lands the cycle after the grant; out-of-range slots carry zero.
    always_comb begin
        s1_resp.valid = s0_valid_q;
        s1_resp.err   = s0_oor_q;
        s1_resp.rdata = s0_oor_q ? 64'h0 : mem_rdata_i;
`ifdef IMEM_RESP_PARITY_EN
        if (s0_valid_q && !s0_oor_q && par_bad) begin
            s1_resp.err = 1'b1;
        end
`endif
    end

    imem_resp_pipe #(
        .Depth (RespLatency - 1)
    ) u_pipe (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .in_i  (s1_resp),
        .out_o (out_resp)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (instr_rvalid_o) begin
            rdata_q <= out_resp.rdata;
            err_q   <= out_resp.err;
        end
    end

    assign instr_rvalid_o = out_resp.valid & ~rst_i;
    assign instr_rdata_o  = instr_rvalid_o ? out_resp.rdata : (rst_i ? 64'h0 : rdata_q);
    assign instr_err_o    = instr_rvalid_o ? out_resp.err : (~rst_i & err_q);
    assign busy_o         = ~rst_i & (count_q != '0);

endmodule
